// File: rtl/vga_pkg.sv
// Shared timing defaults, counter width and FSM encoding for the VGA raster path.
// Defaults describe 640x480 @ 60 Hz from a 100 MHz system clock.
package vga_pkg;

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned CNT_SPAN = 2 ** CNT_W;

  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned DEF_H_VIZ   = 640;
  localparam int unsigned DEF_H_FP    = 16;
  localparam int unsigned DEF_H_PULSE = 96;
  localparam int unsigned DEF_H_BP    = 48;
  localparam int unsigned DEF_H_SYNC  = 800;
  localparam int unsigned DEF_V_VIZ   = 480;
  localparam int unsigned DEF_V_FP    = 10;
  localparam int unsigned DEF_V_PULSE = 2;
  localparam int unsigned DEF_V_BP    = 33;
  localparam int unsigned DEF_V_SYNC  = 525;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vga_state_e;

  // Half-open span test; one extra bit keeps a span ending at CNT_SPAN representable.
  function automatic logic in_span(input logic [CNT_W-1:0] c,
                                   input int unsigned lo,
                                   input int unsigned hi);
    return ({1'b0, c} >= (CNT_W+1)'(lo)) && ({1'b0, c} < (CNT_W+1)'(hi));
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter that wraps at TOTAL, plus visible/sync flags
// for the value the counter will hold after this clock.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL = DEF_H_SYNC,
  parameter int unsigned VIZ   = DEF_H_VIZ,
  parameter int unsigned FP    = DEF_H_FP,
  parameter int unsigned PULSE = DEF_H_PULSE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             viz_nxt,
  output logic             sync_nxt
);

  localparam int unsigned SYNC_LO = VIZ + FP;
  localparam int unsigned SYNC_HI = VIZ + FP + PULSE;

  logic [CNT_W-1:0] cnt_nxt;

  // Next position and the region flags that describe it
  always_comb begin
    wrap    = inc && (cnt == CNT_W'(TOTAL - 1));
    cnt_nxt = cnt;
    if (clr || wrap) begin
      cnt_nxt = '0;
    end else if (inc) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
    viz_nxt  = ({1'b0, cnt_nxt} < (CNT_W+1)'(VIZ));
    sync_nxt = in_span(cnt_nxt, SYNC_LO, SYNC_HI);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing stage: pixel clock-enable, h/v position counters, sync pulses,
// active-video flag and line/frame strobes for the downstream pattern stage.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_VIZ    = DEF_H_VIZ,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_PULSE  = DEF_H_PULSE,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned V_VIZ    = DEF_V_VIZ,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_PULSE  = DEF_V_PULSE,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_ce,
  output logic [CNT_W-1:0] h_poz,
  output logic [CNT_W-1:0] v_poz,
  output logic             h_out,
  output logic             v_out,
  output logic             active,
  output logic             line_start,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if ((H_SYNC > CNT_SPAN) || (V_SYNC > CNT_SPAN)) begin : g_bad_total
    $error("vga_timing_gen: H_SYNC/V_SYNC exceed counter range");
  end
  if (H_VIZ + H_FP + H_PULSE + H_BP != H_SYNC) begin : g_bad_h_sum
    $error("vga_timing_gen: horizontal regions do not sum to H_SYNC");
  end
  if (V_VIZ + V_FP + V_PULSE + V_BP != V_SYNC) begin : g_bad_v_sum
    $error("vga_timing_gen: vertical regions do not sum to V_SYNC");
  end

  vga_state_e      state_q;
  vga_state_e      state_nxt;
  logic [PS_W-1:0] ps_q;
  logic            ps_last;
  logic            idle;
  logic            live_nxt;
  logic            h_wrap;
  logic            v_wrap;
  logic            h_viz_nxt;
  logic            v_viz_nxt;
  logic            h_sync_nxt;
  logic            v_sync_nxt;

  assign ps_last  = (ps_q == PS_W'(CLK_DIV - 1));
  assign idle     = (state_q == IDLE);
  assign live_nxt = (state_nxt != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // DRAIN only retires on the last pixel of a frame so frames are never cut short
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:  if (en) state_nxt = RUN;
      RUN:   if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en) begin
          state_nxt = RUN;
        end else if (v_wrap) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    pix_ce      = 1'b0;
    line_start  = 1'b0;
    frame_start = 1'b0;
    if (!idle) begin
      busy        = 1'b1;
      pix_ce      = ps_last;
      line_start  = ps_last && (h_poz == '0);
      frame_start = ps_last && (h_poz == '0) && (v_poz == '0);
    end
  end

  // Prescaler sits at 0 in IDLE so every run starts on a fresh pixel period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q <= '0;
    end else if (idle || ps_last) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + PS_W'(1);
    end
  end

  vga_axis_cnt #(
    .TOTAL (H_SYNC),
    .VIZ   (H_VIZ),
    .FP    (H_FP),
    .PULSE (H_PULSE)
  ) u_h_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (idle),
    .inc      (pix_ce),
    .cnt      (h_poz),
    .wrap     (h_wrap),
    .viz_nxt  (h_viz_nxt),
    .sync_nxt (h_sync_nxt)
  );

  vga_axis_cnt #(
    .TOTAL (V_SYNC),
    .VIZ   (V_VIZ),
    .FP    (V_FP),
    .PULSE (V_PULSE)
  ) u_v_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (idle),
    .inc      (h_wrap),
    .cnt      (v_poz),
    .wrap     (v_wrap),
    .viz_nxt  (v_viz_nxt),
    .sync_nxt (v_sync_nxt)
  );

  // Flags are built from next-cycle counter values so they line up with h_poz/v_poz
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      h_out  <= ~SYNC_POL;
      v_out  <= ~SYNC_POL;
    end else begin
      active <= live_nxt && h_viz_nxt && v_viz_nxt;
      h_out  <= (live_nxt && h_sync_nxt) ? SYNC_POL : ~SYNC_POL;
      v_out  <= (live_nxt && v_sync_nxt) ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule
